// File: rtl/sntrup_pkg.sv
// Shared definitions for the SNTRU Prime 761 datapaths (encapsulation,
// decapsulation, key generation).
//   - ring parameters P, Q and the centring threshold (Q-1)/2
//   - RAM address / coefficient data widths
//   - the run-controller state encoding shared by the streaming datapaths
package sntrup_pkg;

  localparam int AW = 11;
  localparam int DW = 13;

  localparam int P      = 761;
  localparam int Q      = 4591;
  localparam int HALF_Q = (Q - 1) / 2;  // 2295

  // Sized forms so comparisons against data/address fields stay width-exact.
  localparam logic [DW-1:0] Q_W      = DW'(Q);
  localparam logic [DW-1:0] HALF_Q_W = DW'(HALF_Q);
  localparam logic [AW-1:0] P_LAST_W = AW'(P - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/round3_mod_q.sv
// Combinational Round() for SNTRU Prime 761: maps u in 0..Q-1 to the nearest
// multiple of 3 of its centred representative, returned again in 0..Q-1.
//   u : coefficient, unsigned 0..Q-1 (values >= Q give a defined but
//       meaningless result)
//   y : Round(u) mod Q
// The arithmetic stays in the unsigned mod-Q domain: with x = u or u - Q,
// x mod 3 follows from u mod 3 because Q = 1 (mod 3), and the +/-1
// correction is applied to u directly, folding the single overflow case
// (u = Q-1, x = -1 -> 0) back with one conditional subtract of Q.
module round3_mod_q
  import sntrup_pkg::*;
(
  input  logic [DW-1:0] u,
  output logic [DW-1:0] y
);

  logic [DW-1:0] rem_u;
  logic [1:0]    r_x;
  logic [DW:0]   w;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    rem_u = u % DW'(3);
    r_x   = rem_u[1:0];
    // Negative half: x = u - Q, and Q = 1 (mod 3), so x mod 3 = (u mod 3) - 1.
    if (u > HALF_Q_W) begin
      r_x = (rem_u[1:0] == 2'd0) ? 2'd2 : rem_u[1:0] - 2'd1;
    end

    w = {1'b0, u};
    case (r_x)
      2'd1:    w = w - (DW+1)'(1);
      2'd2:    w = w + (DW+1)'(1);
      default: w = {1'b0, u};
    endcase

    if (w >= {1'b0, Q_W}) begin
      w = w - {1'b0, Q_W};
    end
    y = w[DW-1:0];
  end

endmodule

// File: rtl/encap_round_dp.sv
// Encapsulation rounding datapath for SNTRU Prime 761.
// Streams P coefficients of h*r from a synchronous-read RAM, applies Round()
// and writes the results into the ciphertext RAM at the same index.
//   clk, rst : clock, asynchronous active-high reset
//   start    : one-cycle run request, honoured only in IDLE
//   busy     : high while a run is in progress
//   done     : one-cycle pulse, one cycle after the last write
//   rd_addr  : product RAM read address (data returns one cycle later)
//   rd_data  : product RAM read data
//   wr_en    : ciphertext RAM write strobe
//   wr_addr  : ciphertext RAM write address (trails rd_addr by 2)
//   wr_data  : rounded coefficient, 0..Q-1
// Pipeline: cycle t presents rd_addr=k, cycle t+1 has rd_data=mem[k], cycle
// t+2 has the registered write. The 2-cycle lag makes in-place use of one
// dual-port RAM safe.
module encap_round_dp
  import sntrup_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);

  state_t        state;
  logic          drain_cnt;
  logic          rd_valid;  // rd_data carries a coefficient of this run
  logic [AW-1:0] rd_idx;    // index belonging to rd_data
  logic [DW-1:0] rounded;

  round3_mod_q u_round (
    .u (rd_data),
    .y (rounded)
  );

  // Run controller. rd_addr doubles as the index counter.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_addr   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_READ;
            busy    <= 1'b1;
            rd_addr <= '0;
          end
        end
        ST_READ: begin
          if (rd_addr == P_LAST_W) begin
            state     <= ST_DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        ST_DRAIN: begin
          // Two cycles: one for the RAM read latency, one for the round stage.
          if (drain_cnt) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          rd_addr <= '0;
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          rd_addr <= '0;
        end
      endcase
    end
  end

  // Read-latency stage and round stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      rd_valid <= (state == ST_READ);
      rd_idx   <= rd_addr;
      wr_en    <= rd_valid;
      if (rd_valid) begin
        wr_addr <= rd_idx;
        wr_data <= rounded;
      end
    end
  end

endmodule

// File: tb/tb_encap_round_dp.sv
// Scoreboard bench for encap_round_dp: each run pushes its 761 expected
// writes; an independent monitor pops and compares on every wr_en.
module tb_encap_round_dp;

  localparam int P  = 761;
  localparam int Q  = 4591;
  localparam int HQ = 2295;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, wr_en;
  logic [10:0] rd_addr, wr_addr;
  logic [12:0] rd_data = '0;
  logic [12:0] wr_data;

  logic [12:0] mem [0:2047];

  typedef struct {
    int addr;
    int data;
  } exp_t;
  exp_t q[$];

  int n_vec  = 0;
  int n_miss = 0;

  // Directed (input, hand-computed Round) pairs placed at addresses 10..18.
  int dir_u [9] = '{0, 1, 2, 2294, 2295, 2296, 2297, 4589, 4590};
  int dir_e [9] = '{0, 0, 3, 2295, 2295, 2296, 2296, 4588, 0};

  encap_round_dp dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read product RAM.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference Round on the signed centred value.
  function automatic int ref_round(input int u);
    int x, r, y;
    x = (u <= HQ) ? u : u - Q;
    r = ((x % 3) + 3) % 3;
    y = (r == 0) ? x : (r == 1) ? x - 1 : x + 1;
    return (y < 0) ? y + Q : y;
  endfunction

  task automatic push_run(input bit use_dir);
    exp_t e;
    for (int k = 0; k < P; k++) begin
      e.addr = k;
      e.data = ref_round(int'(mem[k]));
      if (use_dir && k >= 10 && k < 19) e.data = dir_e[k-10];
      q.push_back(e);
    end
  endtask

  // Monitor: compare every presented write against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    int c;
    if (wr_en) begin
      if (q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_unexpected_write: got addr %0d, expected no write", wr_addr);
      end else begin
        e = q.pop_front();
        check("wr_addr", int'(wr_addr), e.addr);
        check("wr_data", int'(wr_data), e.data);
        c = (int'(wr_data) <= HQ) ? int'(wr_data) : int'(wr_data) - Q;
        check("centred_mult3", ((c % 3) + 3) % 3, 0);
      end
    end
  end

  // One run: caller is at a negedge. Start is driven now and accepted on the
  // next posedge (cycle 0 follows it). Optional start re-pulses and a reset
  // at given cycles; rst_at < 0 means run to completion.
  task automatic run(input int rp_a, input int rp_b, input int rst_at,
                     output int n_wr, output int n_done,
                     output int done_cyc, output int busy_cyc);
    int i;
    n_wr = 0; n_done = 0; done_cyc = -1; busy_cyc = 0;
    start = 1'b1;
    @(posedge clk);
    i = 0;
    forever begin
      @(negedge clk);
      start = (i == rp_a || i == rp_b);
      if (busy) busy_cyc++;
      if (wr_en) n_wr++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = i;
      end
      if (rst_at >= 0) begin
        if (i == rst_at) begin
          #2;
          rst = 1'b1;
          #1;
          check("rst_busy",    int'(busy),    0);
          check("rst_done",    int'(done),    0);
          check("rst_wr_en",   int'(wr_en),   0);
          check("rst_rd_addr", int'(rd_addr), 0);
          check("rst_wr_addr", int'(wr_addr), 0);
          check("rst_wr_data", int'(wr_data), 0);
          check("rst_pending", q.size(), P - (rst_at - 1));
          q.delete();
        end
        if (i == rst_at + 3) rst = 1'b0;
        if (i == rst_at + 40) break;
      end else begin
        if (i > 0 && !busy) break;
        if (i > 900) begin
          check("run_timeout", i, 764);
          break;
        end
      end
      i++;
    end
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wr, n_done, dcyc, bcyc;

    for (int k = 0; k < 2048; k++) mem[k] = 13'(k % Q);

    // Reset state.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_busy",    int'(busy),    0);
    check("reset_done",    int'(done),    0);
    check("reset_wr_en",   int'(wr_en),   0);
    check("reset_rd_addr", int'(rd_addr), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Run 1: RAM[k] = k.
    push_run(1'b0);
    run(-1, -1, -1, n_wr, n_done, dcyc, bcyc);
    check("r1_writes",   n_wr,   P);
    check("r1_done_cnt", n_done, 1);
    check("r1_done_cyc", dcyc,   763);
    check("r1_busy_cyc", bcyc,   764);
    check("r1_sb_empty", q.size(), 0);
    repeat (3) @(negedge clk);

    // Run 2: directed boundary values, start re-pulsed at cycles 5 and 400.
    for (int j = 0; j < 9; j++) mem[10+j] = 13'(dir_u[j]);
    push_run(1'b1);
    run(5, 400, -1, n_wr, n_done, dcyc, bcyc);
    check("r2_writes",   n_wr,   P);
    check("r2_done_cnt", n_done, 1);
    check("r2_done_cyc", dcyc,   763);
    check("r2_busy_cyc", bcyc,   764);
    check("r2_sb_empty", q.size(), 0);
    repeat (3) @(negedge clk);

    // Run 3: reset at cycle 300; writes 0..298 seen, nothing afterwards.
    push_run(1'b1);
    run(-1, -1, 300, n_wr, n_done, dcyc, bcyc);
    check("r3_writes",   n_wr,   299);
    check("r3_done_cnt", n_done, 0);

    // Run 4: fresh start rewrites 0..760.
    push_run(1'b1);
    run(-1, -1, -1, n_wr, n_done, dcyc, bcyc);
    check("r4_writes",   n_wr,   P);
    check("r4_done_cyc", dcyc,   763);
    check("r4_sb_empty", q.size(), 0);

    // Run 5: back-to-back, start in the first cycle with busy low; random data.
    for (int k = 0; k < P; k++) mem[k] = 13'($urandom_range(Q - 1, 0));
    push_run(1'b0);
    run(-1, -1, -1, n_wr, n_done, dcyc, bcyc);
    check("r5_writes",   n_wr,   P);
    check("r5_done_cnt", n_done, 1);
    check("r5_done_cyc", dcyc,   763);
    check("r5_busy_cyc", bcyc,   764);
    check("r5_sb_empty", q.size(), 0);

    repeat (5) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
